// File: rtl/gpio_link_pkg.sv
// Shared definitions for the GPIO message link (receiver and transmitter).
package gpio_link_pkg;
   typedef enum logic [1:0] {IDLE, BIT_WAIT, BIT_RELEASE, DONE} link_state_t;

   localparam int DEF_WORDS      = 4;
   localparam int DEF_WORD_WIDTH = 32;
   // Bits travel MSB first, word 0 first.
   localparam bit MSB_FIRST      = 1'b1;
endpackage

// File: rtl/gpio_sync.sv
// N-flop synchroniser for one asynchronous link input.
module gpio_sync #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sr <= '0;
      else        sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];
endmodule

// File: rtl/gpio_link_receiver.sv
// GPIO link receiver: per-bit strobe/ack deserialiser with valid/taken output.
// Optional GPIO_RX_PARITY_EN appends an even-parity bit to every frame.
module gpio_link_receiver
   import gpio_link_pkg::*;
#(
   parameter int WORDS       = DEF_WORDS,
   parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
   parameter int SYNC_STAGES = 2,
   localparam int MSG_W      = WORDS * WORD_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             link_req,
   input  logic             link_data,
   input  logic             link_strobe,
   output logic             link_ack,
   output logic [MSG_W-1:0] message_out,
   output logic             message_valid,
   input  logic             message_taken,
   output logic             busy,
   output logic             frame_error
);
`ifdef GPIO_RX_PARITY_EN
   localparam int TARGET = MSG_W + 1;
`else
   localparam int TARGET = MSG_W;
`endif
   localparam int CNT_W = $clog2(TARGET + 1);

   link_state_t      state, state_next;
   logic             req_s, data_s, strobe_s;
   logic [CNT_W-1:0] cnt;
   logic [MSG_W-1:0] shreg;
   logic             last, abort;
`ifdef GPIO_RX_PARITY_EN
   logic             par_bit;
`endif

   gpio_sync #(.STAGES(SYNC_STAGES)) u_sync_req    (.clock(clock), .reset(reset), .d(link_req),    .q(req_s));
   gpio_sync #(.STAGES(SYNC_STAGES)) u_sync_data   (.clock(clock), .reset(reset), .d(link_data),   .q(data_s));
   gpio_sync #(.STAGES(SYNC_STAGES)) u_sync_strobe (.clock(clock), .reset(reset), .d(link_strobe), .q(strobe_s));

   assign last  = (cnt == CNT_W'(TARGET));
   // Once the final bit is in, a dropped request no longer aborts the frame.
   assign abort = !req_s && ((state == BIT_WAIT) || (state == BIT_RELEASE && !last));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:        if (req_s && !message_valid) state_next = BIT_WAIT;
         BIT_WAIT:    if (abort) state_next = IDLE;
                      else if (strobe_s) state_next = BIT_RELEASE;
         BIT_RELEASE: if (abort) state_next = IDLE;
                      else if (!strobe_s) state_next = last ? DONE : BIT_WAIT;
         DONE:        state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         link_ack      <= 1'b0;
         message_out   <= '0;
         message_valid <= 1'b0;
         frame_error   <= 1'b0;
         cnt           <= '0;
         shreg         <= '0;
`ifdef GPIO_RX_PARITY_EN
         par_bit       <= 1'b0;
`endif
      end else begin
         frame_error <= 1'b0;
         if (message_taken && message_valid) message_valid <= 1'b0;
         if (abort) begin
            frame_error <= 1'b1;
            link_ack    <= 1'b0;
            cnt         <= '0;
         end else begin
            case (state)
               BIT_WAIT: if (strobe_s) begin
`ifdef GPIO_RX_PARITY_EN
                  if (cnt == CNT_W'(MSG_W)) par_bit <= data_s;
                  else                      shreg   <= {shreg[MSG_W-2:0], data_s};
`else
                  shreg <= {shreg[MSG_W-2:0], data_s};
`endif
                  cnt      <= cnt + CNT_W'(1);
                  link_ack <= 1'b1;
               end
               BIT_RELEASE: if (!strobe_s) link_ack <= 1'b0;
               // A set in DONE overrides a same-cycle taken.
               DONE: begin
                  cnt <= '0;
`ifdef GPIO_RX_PARITY_EN
                  if (^{shreg, par_bit}) frame_error <= 1'b1;
                  else begin
                     message_out   <= shreg;
                     message_valid <= 1'b1;
                  end
`else
                  message_out   <= shreg;
                  message_valid <= 1'b1;
`endif
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gpio_link_receiver.sv
// Bench for gpio_link_receiver: compliant peer model, frame table, scoreboard.
`timescale 1ns/1ps
module tb_gpio_link_receiver;
   localparam int MSG_W = 128;
`ifdef GPIO_RX_PARITY_EN
   localparam int FRAME_BITS = MSG_W + 1;
`else
   localparam int FRAME_BITS = MSG_W;
`endif

   typedef struct {
      string       name;
      logic [31:0] w0, w1, w2, w3;
      logic [127:0] exp;
   } vec_t;

   logic clock = 1'b0, reset = 1'b0;
   logic link_req = 1'b0, link_data = 1'b0, link_strobe = 1'b0, message_taken = 1'b0;
   logic link_ack, message_valid, busy, frame_error;
   logic [MSG_W-1:0] message_out;

   int errors = 0, checks = 0;
   int ack_pulses = 0, err_pulses = 0;
   int lat_bad = 0, lat_first = 0;
   logic ack_q = 1'b0, valid_q = 1'b0;
   logic [MSG_W-1:0] sb [$];
   logic [MSG_W-1:0] got [$];

   always #5 clock = ~clock;

   gpio_link_receiver dut (
      .clock(clock), .reset(reset), .link_req(link_req), .link_data(link_data),
      .link_strobe(link_strobe), .link_ack(link_ack), .message_out(message_out),
      .message_valid(message_valid), .message_taken(message_taken), .busy(busy),
      .frame_error(frame_error)
   );

   // Monitor: counts ack pulses and error cycles, captures each new message.
   always @(negedge clock) begin
      ack_q   <= link_ack;
      valid_q <= message_valid;
      if (link_ack && !ack_q) ack_pulses <= ack_pulses + 1;
      if (frame_error) err_pulses <= err_pulses + 1;
      if (message_valid && !valid_q) got.push_back(message_out);
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_ack(input logic v, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (link_ack === v) begin
            n  = i + 1;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send_bit(input logic b, output int n_rise, output bit ok);
      int n;
      link_data = b;
      step();
      link_strobe = 1'b1;
      wait_ack(1'b1, n, ok);
      n_rise = n;
      if (ok && n != 3) lat_bad++;
      link_strobe = 1'b0;
      if (ok) begin
         wait_ack(1'b0, n, ok);
         if (ok && n != 3) lat_bad++;
      end
   endtask

   task automatic send_frame(input logic [MSG_W-1:0] m, input int nbits, input bit flip);
      bit   ok;
      int   n;
      logic b;
      ok = 1'b1;
      link_req = 1'b1;
      for (int i = 0; i < nbits && ok; i++) begin
         if (i < MSG_W) b = m[MSG_W-1-i];
         else           b = (^m) ^ flip;
         send_bit(b, n, ok);
         if (i == 0) lat_first = n;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ack_handshake: got timeout want ack edge");
      end
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (message_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      step();
      check({name, "_valid"}, MSG_W'(seen), MSG_W'(1));
   endtask

   task automatic compare_sb(input string name);
      if (got.size() == 0 || sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_sb: got %0d messages want %0d", name, got.size(), sb.size());
      end else check({name, "_msg"}, got.pop_front(), sb.pop_front());
   endtask

   task automatic take();
      message_taken = 1'b1;
      step();
      message_taken = 1'b0;
      step();
      check("taken_clears", MSG_W'(message_valid), '0);
   endtask

   function automatic vec_t mk(input string nm, input logic [31:0] a, b, c, d, input logic [127:0] e);
      vec_t v;
      v.name = nm; v.w0 = a; v.w1 = b; v.w2 = c; v.w3 = d; v.exp = e;
      return v;
   endfunction

   initial begin
      vec_t vt [4];
      int   a0, e0;
      vt[0] = mk("nominal", 32'h00000156, 32'h00000C49, 32'h0000730F, 32'h000E5597,
                 128'h00000156_00000C49_0000730F_000E5597);
      vt[1] = mk("alt",     32'hAAAAAAAA, 32'h55555555, 32'h0F0F0F0F, 32'hF0F0F0F0,
                 128'hAAAAAAAA_55555555_0F0F0F0F_F0F0F0F0);
      vt[2] = mk("zeros",   32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 128'h0);
      vt[3] = mk("edges",   32'h80000000, 32'h00000001, 32'h12345678, 32'h80000001,
                 128'h80000000_00000001_12345678_80000001);

      step();
      step();
      check("rst_ack",   MSG_W'(link_ack), '0);
      check("rst_msg",   message_out, '0);
      check("rst_valid", MSG_W'(message_valid), '0);
      check("rst_busy",  MSG_W'(busy), '0);
      check("rst_err",   MSG_W'(frame_error), '0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 4; i++) begin
         a0 = ack_pulses;
         e0 = err_pulses;
         lat_bad = 0;
         sb.push_back(vt[i].exp);
         send_frame({vt[i].w0, vt[i].w1, vt[i].w2, vt[i].w3}, FRAME_BITS, 1'b0);
         link_req = 1'b0;
         wait_valid(vt[i].name);
         compare_sb(vt[i].name);
         check({vt[i].name, "_acks"},  MSG_W'(ack_pulses - a0), MSG_W'(FRAME_BITS));
         check({vt[i].name, "_noerr"}, MSG_W'(err_pulses - e0), '0);
         check({vt[i].name, "_lat"},   MSG_W'(lat_bad), '0);
         if (i == 0) check("latency_rise", MSG_W'(lat_first), MSG_W'(3));
         if (i < 3) take();
      end

      // Backpressure: valid still set, request must be held off.
      link_req = 1'b1;
      repeat (20) step();
      check("bp_ack",  MSG_W'(link_ack), '0);
      check("bp_busy", MSG_W'(busy), '0);
      sb.push_back(128'h01234567_89ABCDEF_FEDCBA98_76543210);
      take();
      send_frame(128'h01234567_89ABCDEF_FEDCBA98_76543210, FRAME_BITS, 1'b0);
      link_req = 1'b0;
      wait_valid("bp_second");
      compare_sb("bp_second");
      take();

      // Abort after bit 40.
      e0 = err_pulses;
      send_frame({128{1'b1}}, 40, 1'b0);
      link_req = 1'b0;
      repeat (8) step();
      check("abort_err",   MSG_W'(err_pulses - e0), MSG_W'(1));
      check("abort_ack",   MSG_W'(link_ack), '0);
      check("abort_busy",  MSG_W'(busy), '0);
      check("abort_hold",  message_out, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
      check("abort_valid", MSG_W'(message_valid), '0);
      sb.push_back({128{1'b1}});
      send_frame({128{1'b1}}, FRAME_BITS, 1'b0);
      link_req = 1'b0;
      wait_valid("ones");
      compare_sb("ones");
      take();

      // Reset after bit 100.
      send_frame({4{32'hDEADBEEF}}, 100, 1'b0);
      reset = 1'b0;
      #1;
      check("mrst_ack",   MSG_W'(link_ack), '0);
      check("mrst_msg",   message_out, '0);
      check("mrst_valid", MSG_W'(message_valid), '0);
      check("mrst_busy",  MSG_W'(busy), '0);
      link_req = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      repeat (2) step();
      sb.push_back(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
      send_frame({4{32'hDEADBEEF}}, FRAME_BITS, 1'b0);
      link_req = 1'b0;
      wait_valid("deadbeef");
      compare_sb("deadbeef");
      take();

`ifdef GPIO_RX_PARITY_EN
      e0 = err_pulses;
      send_frame(128'h00000156_00000C49_0000730F_000E5597, FRAME_BITS, 1'b1);
      link_req = 1'b0;
      repeat (8) step();
      check("par_err",   MSG_W'(err_pulses - e0), MSG_W'(1));
      check("par_valid", MSG_W'(message_valid), '0);
      check("par_hold",  message_out, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
      sb.push_back(128'h00000156_00000C49_0000730F_000E5597);
      send_frame(128'h00000156_00000C49_0000730F_000E5597, FRAME_BITS, 1'b0);
      link_req = 1'b0;
      wait_valid("par_good");
      compare_sb("par_good");
`endif

      check("sb_drained", MSG_W'(sb.size() + got.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
